// File: rtl/bcd_scan_display_if.sv
// Handshake and display bus for bcd_scan_display.
//   value/load : binary value and its conversion request (driven by the master)
//   busy       : conversion in progress
//   seg        : shared segment bus {g,f,e,d,c,b,a}, active low
//   an         : digit anodes, active low, one-hot
//   dp         : decimal point, active low (always off)
interface bcd_scan_display_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic [WIDTH-1:0]  value;
  logic              load;
  logic              busy;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              dp;

  modport master (output value, load, input busy, seg, an, dp);
  modport slave  (input value, load, output busy, seg, an, dp);
endinterface

// File: rtl/bcd_scan_display.sv
// Binary to multiplexed seven-segment display driver.
// A load captures a binary value, which a double-dabble engine turns into BCD
// at one bit per cycle while busy is high. The finished result goes into a
// display register in a single update. A scanner then shows that register one
// digit per REFRESH_DIV cycles on a common-anode display.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active high
//   bus   : slave side of bcd_scan_display_if (value/load in; busy/seg/an/dp out)
module bcd_scan_display #(
  parameter int WIDTH       = 14,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input logic               clk,
  input logic               reset,
  bcd_scan_display_if.slave bus
);
  localparam int          BCD_W = 4 * DIGITS;
  localparam int          CNT_W = $clog2(WIDTH + 1);
  localparam int          IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int          PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned LIMIT = 10 ** DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // ---------------- converter FSM ----------------
  state_t           state, state_nx;
  logic             capture, step, done, busy, last_iter;
  logic [CNT_W-1:0] cnt;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.load) state_nx = SHIFT;
      SHIFT:   if (last_iter) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    step    = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    case (state)
      IDLE:    capture = bus.load;
      SHIFT: begin
        busy = 1'b1;
        step = 1'b1;
        done = last_iter;
      end
      default: ;
    endcase
  end

  // ---------------- double-dabble datapath ----------------
  logic [WIDTH-1:0]       bin_sr;
  logic [DIGITS-1:0][3:0] bcd, bcd_adj, disp;
  logic [BCD_W-1:0]       bcd_flat, bcd_sh;
  logic                   ovf, disp_ovf;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign bcd_adj[d] = (bcd[d] >= 4'd5) ? bcd[d] + 4'd3 : bcd[d];
  end

  assign bcd_flat = bcd_adj;
  assign bcd_sh   = {bcd_flat[BCD_W-2:0], bin_sr[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sr   <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      disp     <= '0;
      disp_ovf <= 1'b0;
    end else if (capture) begin
      bin_sr <= bus.value;
      bcd    <= '0;
      cnt    <= '0;
      ovf    <= (32'(bus.value) >= LIMIT);
    end else if (step) begin
      bin_sr <= bin_sr << 1;
      bcd    <= bcd_sh;
      cnt    <= cnt + CNT_W'(1);
      // Result and its overflow flag reach the display together so the
      // scanner never sees a half-finished conversion.
      if (done) begin
        disp     <= bcd_sh;
        disp_ovf <= ovf;
      end
    end
  end

  // ---------------- digit decode with leading-zero blanking ----------------
  logic [DIGITS-1:0]      hi_zero;  // digit d and everything above it are zero
  logic [DIGITS-1:0][6:0] seg_dig;
  logic                   run;

  always_comb begin
    hi_zero = '0;
    run     = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      run        = run & (disp[d] == 4'd0);
      hi_zero[d] = run;
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_dec
    logic blank;
    assign blank      = (BLANK_LZ != 0) && (d != 0) && hi_zero[d];
    assign seg_dig[d] = disp_ovf ? SEG_DASH :
                        blank    ? SEG_BLANK : seg7(disp[d]);
  end

  // ---------------- scanner ----------------
  logic [PRE_W-1:0]  presc;
  logic [IDX_W-1:0]  idx;
  logic              wrap, slot_adv;
  logic [6:0]        seg_r;
  logic [DIGITS-1:0] an_r;

  assign wrap = (presc == PRE_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      idx      <= '0;
      slot_adv <= 1'b0;
    end else begin
      presc    <= wrap ? '0 : presc + PRE_W'(1);
      slot_adv <= wrap;
      if (wrap) idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // Outputs reload only on the cycle after the index moves, so seg and an
  // always switch together at slot boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r <= 7'b1000000;
      an_r  <= ~DIGITS'(1);
    end else if (slot_adv) begin
      seg_r <= seg_dig[idx];
      an_r  <= ~(DIGITS'(1) << idx);
    end
  end

  assign bus.busy = busy;
  assign bus.seg  = seg_r;
  assign bus.an   = an_r;
  assign bus.dp   = 1'b1;
endmodule
